median_filter_1d: RTL and testbench



---
 rtl/median_filter_1d.sv | 88 ++++++++
 tb/tb_median_filter_1d.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_filter_1d.sv
// Streaming 1-D median filter: sliding window of the last WINDOW_SIZE
// pixels, sorted by sequential odd-even transposition, median out on ready.
module median_filter_1d #(
    parameter int WINDOW_SIZE = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] new_pixel,
    output logic [DATA_WIDTH-1:0] median_out,
    output logic                  ready,
    output logic                  rdy
);

    localparam int MID = (WINDOW_SIZE - 1) / 2;
    localparam int CW  = $clog2(WINDOW_SIZE + 1);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         pass;
    logic [CW-1:0]         fill;
    logic [DATA_WIDTH-1:0] window [WINDOW_SIZE];
    logic [DATA_WIDTH-1:0] s      [WINDOW_SIZE];
    logic [DATA_WIDTH-1:0] s_next [WINDOW_SIZE];

    // Pairs start at even indices on even passes, odd indices on odd passes.
    always_comb begin
        s_next = s;
        for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
            if (i[0] == pass[0] && s[i] > s[i+1]) begin
                s_next[i]   = s[i+1];
                s_next[i+1] = s[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            pass       <= '0;
            fill       <= '0;
            median_out <= '0;
            ready      <= 1'b0;
            rdy        <= 1'b0;
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                window[i] <= '0;
                s[i]      <= '0;
            end
        end else begin
            ready <= 1'b0;
            unique case (state)
                LOAD: begin
                    window[0] <= new_pixel;
                    s[0]      <= new_pixel;
                    for (int i = 1; i < WINDOW_SIZE; i++) begin
                        window[i] <= window[i-1];
                        s[i]      <= window[i-1];
                    end
                    pass <= '0;
                    if (fill != CW'(WINDOW_SIZE))
                        fill <= fill + CW'(1);
                    state <= SORT;
                end
                SORT: begin
                    s <= s_next;
                    if (pass == CW'(WINDOW_SIZE - 1))
                        state <= DONE;
                    else
                        pass <= pass + CW'(1);
                end
                DONE: begin
                    median_out <= s[MID];
                    ready      <= 1'b1;
                    if (fill == CW'(WINDOW_SIZE))
                        rdy <= 1'b1;
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_median_filter_1d.sv
// Directed bench for median_filter_1d: W=3 instance plus a W=5 instance,
// hand-computed medians, strobe spacing and reset behaviour.
module tb_median_filter_1d;

    logic       clk;
    logic       rst;
    logic [7:0] pix3;
    logic [7:0] pix5;
    logic [7:0] med3;
    logic [7:0] med5;
    logic       ready3;
    logic       ready5;
    logic       rdy3;
    logic       rdy5;

    int errors;
    int checks;

    median_filter_1d #(.WINDOW_SIZE(3), .DATA_WIDTH(8)) u3 (
        .clk        (clk),
        .rst        (rst),
        .new_pixel  (pix3),
        .median_out (med3),
        .ready      (ready3),
        .rdy        (rdy3)
    );

    median_filter_1d #(.WINDOW_SIZE(5), .DATA_WIDTH(8)) u5 (
        .clk        (clk),
        .rst        (rst),
        .new_pixel  (pix5),
        .median_out (med5),
        .ready      (ready5),
        .rdy        (rdy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Apply a pixel and count edges until the next ready strobe (-1 on timeout).
    task automatic step(input int sel, input logic [7:0] p,
                        output logic [7:0] med, output logic r,
                        output int lat);
        logic got;
        got = 1'b0;
        lat = -1;
        if (sel == 5) pix5 = p;
        else pix3 = p;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if ((sel == 5 && ready5) || (sel != 5 && ready3)) begin
                got = 1'b1;
                lat = c;
            end
        end
        med = (sel == 5) ? med5 : med3;
        r   = (sel == 5) ? rdy5 : rdy3;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        pix3 = 8'hAA;
        pix5 = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (med3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_median got=%h want=00", med3);
        end
        checks++;
        if (ready3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b want=0", ready3);
        end
        checks++;
        if (rdy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy got=%b want=0", rdy3);
        end
        checks++;
        if (med5 !== 8'h00 || ready5 !== 1'b0 || rdy5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w5 got=%h/%b/%b want=00/0/0",
                     med5, ready5, rdy5);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reference();
        logic [7:0] in  [9] = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01,
                                8'hFE, 8'h81, 8'h7E, 8'h02};
        logic [7:0] exp [9] = '{8'h00, 8'h00, 8'h80, 8'h7F, 8'h7F,
                                8'h7F, 8'h81, 8'h81, 8'h7E};
        logic [7:0] m;
        logic       r;
        int         lat;
        for (int k = 0; k < 9; k++) begin
            step(3, in[k], m, r, lat);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL ref_latency[%0d] got=%0d want=5", k, lat);
            end
            checks++;
            if (m !== exp[k]) begin
                errors++;
                $display("FAIL ref_median[%0d] got=%h want=%h", k, m, exp[k]);
            end
            checks++;
            if (r !== (k >= 2)) begin
                errors++;
                $display("FAIL ref_rdy[%0d] got=%b want=%b", k, r, k >= 2);
            end
        end
    endtask

    task automatic test_strobe_shape();
        logic [7:0] exp [4] = '{8'h00, 8'h55, 8'h55, 8'h55};
        logic [7:0] m;
        logic       r;
        int         lat;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(3, 8'h55, m, r, lat);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL strobe_spacing[%0d] got=%0d want=5", k, lat);
            end
            checks++;
            if (m !== exp[k]) begin
                errors++;
                $display("FAIL strobe_median[%0d] got=%h want=%h", k, m, exp[k]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready3 !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width got=%b want=0", ready3);
        end
    endtask

    task automatic test_duplicates();
        logic [7:0] in  [5] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h20};
        logic [7:0] exp [5] = '{8'h00, 8'h10, 8'h10, 8'h20, 8'h20};
        logic [7:0] m;
        logic       r;
        int         lat;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(3, in[k], m, r, lat);
            checks++;
            if (m !== exp[k] || lat !== 5) begin
                errors++;
                $display("FAIL dup_median[%0d] got=%h lat=%0d want=%h lat=5",
                         k, m, lat, exp[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] m;
        logic       r;
        int         lat;
        logic       seen;
        do_reset();
        step(3, 8'h30, m, r, lat);
        step(3, 8'h40, m, r, lat);
        step(3, 8'h50, m, r, lat);
        pix3 = 8'h60;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready3) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_ready got=%b want=0", seen);
        end
        checks++;
        if (med3 !== 8'h00 || rdy3 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h/%b want=00/0", med3, rdy3);
        end
        @(negedge clk);
        rst = 1'b0;
        step(3, 8'h90, m, r, lat);
        checks++;
        if (m !== 8'h00 || r !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL midrst_restart got=%h/%b lat=%0d want=00/0 lat=5",
                     m, r, lat);
        end
    endtask

    task automatic test_sweep_w5();
        logic [7:0] in  [5] = '{8'h05, 8'h01, 8'h04, 8'h02, 8'h03};
        logic [7:0] exp [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        logic [7:0] m;
        logic       r;
        int         lat;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(5, in[k], m, r, lat);
            checks++;
            if (lat !== 7) begin
                errors++;
                $display("FAIL w5_spacing[%0d] got=%0d want=7", k, lat);
            end
            checks++;
            if (m !== exp[k]) begin
                errors++;
                $display("FAIL w5_median[%0d] got=%h want=%h", k, m, exp[k]);
            end
            checks++;
            if (r !== (k == 4)) begin
                errors++;
                $display("FAIL w5_rdy[%0d] got=%b want=%b", k, r, k == 4);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_reference();
        test_strobe_shape();
        test_duplicates();
        test_mid_reset();
        test_sweep_w5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
